// File: rtl/cv32e40s_pkg.sv
// Shared types and limits for the LSU response tracker.
package cv32e40s_pkg;

  localparam int LSU_TRK_MAX_DEPTH  = 8;
  localparam int LSU_TRK_MAX_ADDR_W = 32;

  typedef struct packed {
    logic                          bufferable;
    logic                          store;
    logic [LSU_TRK_MAX_ADDR_W-1:0] addr;
  } lsu_trk_entry_t;

endpackage

// File: rtl/cv32e40s_lsu_outstanding_fifo.sv
// In-order FIFO of outstanding LSU transfers: one write pointer and two
// independent read pointers (bus side, core side), each with its own count.
module cv32e40s_lsu_outstanding_fifo
  import cv32e40s_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  lsu_trk_entry_t wdata,
  input  logic           bus_pop,
  input  logic           core_pop,
  output lsu_trk_entry_t bus_head,
  output lsu_trk_entry_t core_head,
  output logic           heads_aligned,
  output logic [CW-1:0]  bus_cnt,
  output logic [CW-1:0]  core_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lsu_trk_entry_t mem [DEPTH];
  logic [PW-1:0]  wptr, bus_rptr, core_rptr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      bus_rptr  <= '0;
      core_rptr <= '0;
      bus_cnt   <= '0;
      core_cnt  <= '0;
    end else begin
      if (push)     wptr      <= inc(wptr);
      if (bus_pop)  bus_rptr  <= inc(bus_rptr);
      if (core_pop) core_rptr <= inc(core_rptr);
      bus_cnt  <= bus_cnt  + CW'(push) - CW'(bus_pop);
      core_cnt <= core_cnt + CW'(push) - CW'(core_pop);
    end
  end

  assign bus_head      = mem[bus_rptr];
  assign core_head     = mem[core_rptr];
  assign heads_aligned = (core_rptr == bus_rptr);

endmodule

// File: rtl/cv32e40s_lsu_response_tracker.sv
// LSU response tracker: early responses for bufferable transfers, pass-through
// otherwise, sticky imprecise error. CV32E40S_LSU_ERR_ADDR_CAPTURE_EN adds address capture.
module cv32e40s_lsu_response_tracker
  import cv32e40s_pkg::*;
#(
  parameter  int DEPTH      = 2,
  parameter  int ADDR_WIDTH = 32,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic                  bufferable_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  resp_valid_i,
  input  logic                  resp_err_i,
  output logic                  resp_valid_o,
  output logic                  resp_err_o,
  output logic                  busy_o,
  output logic [CW-1:0]         bus_cnt_o,
  output logic                  imp_err_o,
  output logic                  imp_err_store_o,
  output logic [ADDR_WIDTH-1:0] imp_err_addr_o,
  input  logic                  imp_err_clr_i
);

  lsu_trk_entry_t wentry, bus_head, core_head;
  logic           heads_aligned;
  logic [CW-1:0]  bus_cnt, core_cnt;
  logic           not_full, accept, bus_resp, imp_set;
  logic           imp_err_q, imp_store_q;

  // Limit uses the registered count, so a response in a full cycle frees a slot next cycle.
  assign not_full = bus_cnt < CW'(DEPTH);
  assign valid_o  = valid_i && not_full;
  assign ready_o  = ready_i && not_full;
  assign accept   = valid_o && ready_i;
  assign bus_resp = resp_valid_i && (bus_cnt != '0);
  assign busy_o   = (bus_cnt != '0) || valid_i;
  assign bus_cnt_o = bus_cnt;

  assign resp_valid_o = (core_cnt != '0) &&
                        (core_head.bufferable || (resp_valid_i && heads_aligned));
  assign resp_err_o   = resp_valid_o && resp_err_i && !core_head.bufferable;

  always_comb begin
    wentry            = '0;
    wentry.bufferable = bufferable_i;
    wentry.store      = we_i;
`ifdef CV32E40S_LSU_ERR_ADDR_CAPTURE_EN
    wentry.addr       = LSU_TRK_MAX_ADDR_W'(addr_i);
`endif
  end

  cv32e40s_lsu_outstanding_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (accept),
    .wdata         (wentry),
    .bus_pop       (bus_resp),
    .core_pop      (resp_valid_o),
    .bus_head      (bus_head),
    .core_head     (core_head),
    .heads_aligned (heads_aligned),
    .bus_cnt       (bus_cnt),
    .core_cnt      (core_cnt)
  );

  // First error wins unless a clear coincides, in which case the new one is taken.
  assign imp_set = bus_resp && resp_err_i && bus_head.bufferable &&
                   (!imp_err_q || imp_err_clr_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imp_err_q   <= 1'b0;
      imp_store_q <= 1'b0;
    end else if (imp_set) begin
      imp_err_q   <= 1'b1;
      imp_store_q <= bus_head.store;
    end else if (imp_err_clr_i) begin
      imp_err_q   <= 1'b0;
    end
  end

  assign imp_err_o       = imp_err_q;
  assign imp_err_store_o = imp_store_q;

`ifdef CV32E40S_LSU_ERR_ADDR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] imp_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          imp_addr_q <= '0;
    else if (imp_set) imp_addr_q <= bus_head.addr[ADDR_WIDTH-1:0];
  end

  assign imp_err_addr_o = imp_addr_q;
`else
  assign imp_err_addr_o = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr_i, bus_head.addr, core_head.store, core_head.addr};

`ifndef SYNTHESIS
  a_core_le_bus: assert property (@(posedge clk) disable iff (rst) core_cnt <= bus_cnt)
    else $error("core_cnt exceeds bus_cnt");
  a_no_spurious: assert property (@(posedge clk) disable iff (rst)
                                  !(resp_valid_i && bus_cnt == '0))
    else $warning("bus response with nothing outstanding was ignored");
`endif

endmodule
